// File: rtl/i2c_target_if.sv
// rtl/i2c_target_if.sv - I2C bus wires between initiator and target
interface i2c_target_if;
  logic scl;
  logic sda_out;
  logic sda_oe;
  logic sda_in;

  modport master (output scl, output sda_out, output sda_oe, input sda_in);
  modport slave  (input scl, input sda_out, input sda_oe, output sda_in);
endinterface

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target with one 7-bit address and 16-bit transfers
module i2c_target #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i2c_addr,
  input  logic [DATA_W-1:0] rd_data,
  i2c_target_if.slave       bus,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_valid,
  output logic              busy
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] ADDR      = 4'd1;
  localparam logic [3:0] ADDR_ACK  = 4'd2;
  localparam logic [3:0] WR_BYTE   = 4'd3;
  localparam logic [3:0] WR_ACK    = 4'd4;
  localparam logic [3:0] WR_FULL   = 4'd5;
  localparam logic [3:0] RD_BYTE   = 4'd6;
  localparam logic [3:0] RD_ACK    = 4'd7;
  localparam logic [3:0] WAIT_STOP = 4'd8;

  logic [3:0]        state;
  logic [2:0]        bit_cnt;
  logic              byte_idx;   // 0 = first byte, 1 = second byte
  logic              byte_done;  // 8th rise seen, act on the next fall
  logic              ack_bit;
  logic [ADDR_W:0]   addr_sr;    // address bits then rnw in bit 0
  logic [DATA_W-1:0] rx;
  logic [DATA_W-1:0] tx;
  logic              scl_q;
  logic              sda_q;
  logic              sda_line;
  logic              rise;
  logic              fall;
  logic              start_c;
  logic              stop_c;

  // Resolved bus value as seen by both ends, plus edge and condition decode
  always_comb begin
    sda_line = bus.sda_oe ? bus.sda_out : bus.sda_in;
    rise     = bus.scl & ~scl_q;
    fall     = ~bus.scl & scl_q;
    start_c  = sda_q & ~sda_line & bus.scl & scl_q;
    stop_c   = ~sda_q & sda_line & bus.scl & scl_q;
  end

  // Protocol state machine; start/stop override whatever byte phase is active
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      byte_idx   <= 1'b0;
      byte_done  <= 1'b0;
      ack_bit    <= 1'b1;
      addr_sr    <= '0;
      rx         <= '0;
      tx         <= '0;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      bus.sda_in <= 1'b1;
      wr_data    <= '0;
      wr_valid   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      scl_q    <= bus.scl;
      sda_q    <= sda_line;
      wr_valid <= 1'b0;
      if (start_c) begin
        state      <= ADDR;
        bit_cnt    <= 3'd0;
        byte_idx   <= 1'b0;
        byte_done  <= 1'b0;
        busy       <= 1'b1;
        bus.sda_in <= 1'b1;
      end else if (stop_c) begin
        state      <= IDLE;
        busy       <= 1'b0;
        bus.sda_in <= 1'b1;
      end else begin
        if (rise && (state == ADDR || state == WR_BYTE || state == RD_BYTE)) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) byte_done <= 1'b1;
        end
        case (state)
          ADDR: begin
            if (rise) begin
              addr_sr <= {addr_sr[ADDR_W-1:0], sda_line};
            end else if (fall && byte_done) begin
              byte_done <= 1'b0;
              if (addr_sr[ADDR_W:1] == i2c_addr) begin
                bus.sda_in <= 1'b0;
                state      <= ADDR_ACK;
                if (addr_sr[0]) tx <= rd_data;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end
          ADDR_ACK: begin
            if (fall) begin
              if (addr_sr[0]) begin
                bus.sda_in <= tx[DATA_W-1];
                tx         <= tx << 1;
                state      <= RD_BYTE;
              end else begin
                bus.sda_in <= 1'b1;
                state      <= WR_BYTE;
              end
            end
          end
          WR_BYTE: begin
            if (rise) begin
              rx <= {rx[DATA_W-2:0], sda_line};
            end else if (fall && byte_done) begin
              byte_done  <= 1'b0;
              bus.sda_in <= 1'b0;
              state      <= WR_ACK;
            end
          end
          WR_ACK: begin
            if (fall) begin
              bus.sda_in <= 1'b1;
              if (!byte_idx) begin
                byte_idx <= 1'b1;
                state    <= WR_BYTE;
              end else begin
                state    <= WR_FULL;
                wr_data  <= rx;
                wr_valid <= 1'b1;
              end
            end
          end
          RD_BYTE: begin
            if (fall) begin
              if (byte_done) begin
                byte_done  <= 1'b0;
                bus.sda_in <= 1'b1;
                state      <= RD_ACK;
              end else begin
                bus.sda_in <= tx[DATA_W-1];
                tx         <= tx << 1;
              end
            end
          end
          RD_ACK: begin
            if (rise) begin
              ack_bit <= sda_line;
            end else if (fall) begin
              if (!ack_bit && !byte_idx) begin
                byte_idx   <= 1'b1;
                bus.sda_in <= tx[DATA_W-1];
                tx         <= tx << 1;
                state      <= RD_BYTE;
              end else begin
                bus.sda_in <= 1'b1;
                state      <= WAIT_STOP;
              end
            end
          end
          default: bus.sda_in <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - scoreboard bench driving the I2C target as an initiator
module tb_i2c_target;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  i2c_addr;
  logic [15:0] rd_data;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        busy;
  logic        sda_line;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  i2c_target_if bus ();

  i2c_target dut (
    .clk      (clk),
    .reset    (reset),
    .i2c_addr (i2c_addr),
    .rd_data  (rd_data),
    .bus      (bus.slave),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  assign sda_line = bus.sda_oe ? bus.sda_out : bus.sda_in;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write-payload monitor: every wr_valid pulse must match the next expected word
  always @(negedge clk) begin : wr_monitor
    logic [15:0] e;
    if (wr_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_valid_unexpected: got pulse with wr_data 0x%0h expected no pulse", wr_data);
      end else begin
        e = exp_q.pop_front();
        if (wr_data !== e) begin
          n_fail++;
          $display("FAIL wr_data: got 0x%0h expected 0x%0h", wr_data, e);
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic oe, input logic b, output logic s);
    bus.sda_oe  = oe;
    bus.sda_out = b;
    wait_clk(2);
    bus.scl = 1'b1;
    wait_clk(2);
    s = sda_line;
    wait_clk(2);
    bus.scl = 1'b0;
    wait_clk(2);
  endtask

  task automatic send_start();
    bus.scl = 1'b0;
    wait_clk(2);
    bus.sda_oe  = 1'b1;
    bus.sda_out = 1'b1;
    wait_clk(2);
    bus.scl = 1'b1;
    wait_clk(4);
    bus.sda_out = 1'b0;
    wait_clk(4);
    bus.scl = 1'b0;
    wait_clk(2);
  endtask

  task automatic send_stop();
    bus.sda_oe  = 1'b1;
    bus.sda_out = 1'b0;
    wait_clk(2);
    bus.scl = 1'b1;
    wait_clk(4);
    bus.sda_out = 1'b1;
    wait_clk(4);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(1'b1, b[i], s);
    clock_bit(1'b0, 1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b0, 1'b1, s);
      d[i] = s;
    end
    clock_bit(1'b1, nack, s);
  endtask

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] d;
    reset       = 1'b1;
    i2c_addr    = 7'h2A;
    rd_data     = 16'h0000;
    bus.scl     = 1'b1;
    bus.sda_oe  = 1'b1;
    bus.sda_out = 1'b1;
    @(negedge clk);
    wait_clk(3);
    check("rst_sda_in", 16'(bus.sda_in), 16'h1);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_wr_valid", 16'(wr_valid), 16'h0);
    check("rst_wr_data", wr_data, 16'h0000);
    reset = 1'b0;
    wait_clk(2);

    // Write 0xA5C3 to 0x2A
    send_start();
    check("wr_busy_start", 16'(busy), 16'h1);
    write_byte(8'h54, ack); check("wr_addr_ack", 16'(ack), 16'h0);
    write_byte(8'hA5, ack); check("wr_b0_ack", 16'(ack), 16'h0);
    check("wr_busy_mid", 16'(busy), 16'h1);
    exp_q.push_back(16'hA5C3);
    write_byte(8'hC3, ack); check("wr_b1_ack", 16'(ack), 16'h0);
    send_stop();
    check("wr_busy_stop", 16'(busy), 16'h0);

    // Read 0x1234
    rd_data = 16'h1234;
    send_start();
    write_byte(8'h55, ack); check("rd_addr_ack", 16'(ack), 16'h0);
    read_byte(1'b0, d); check("rd_b0", 16'(d), 16'h0012);
    read_byte(1'b1, d); check("rd_b1", 16'(d), 16'h0034);
    check("rd_released", 16'(bus.sda_in), 16'h1);
    send_stop();
    check("rd_busy_stop", 16'(busy), 16'h0);

    // Address mismatch
    send_start();
    write_byte(8'h56, ack); check("mm_addr_nack", 16'(ack), 16'h1);
    write_byte(8'hA5, ack); check("mm_data_nack", 16'(ack), 16'h1);
    send_stop();
    check("mm_busy_stop", 16'(busy), 16'h0);

    // Stop after one write byte keeps the old payload
    send_start();
    write_byte(8'h54, ack); check("part_addr_ack", 16'(ack), 16'h0);
    write_byte(8'hFF, ack); check("part_b0_ack", 16'(ack), 16'h0);
    send_stop();
    check("part_wr_data", wr_data, 16'hA5C3);
    check("part_busy", 16'(busy), 16'h0);

    // Repeated start abandons the write, then reads 0xBEEF
    rd_data = 16'hBEEF;
    send_start();
    write_byte(8'h54, ack); check("rs_wr_addr_ack", 16'(ack), 16'h0);
    write_byte(8'h11, ack); check("rs_wr_b0_ack", 16'(ack), 16'h0);
    send_start();
    check("rs_busy", 16'(busy), 16'h1);
    write_byte(8'h55, ack); check("rs_rd_addr_ack", 16'(ack), 16'h0);
    read_byte(1'b0, d); check("rs_rd_b0", 16'(d), 16'h00BE);
    read_byte(1'b1, d); check("rs_rd_b1", 16'(d), 16'h00EF);
    send_stop();
    check("rs_wr_data", wr_data, 16'hA5C3);

    // Reset during bit 3 of the first read byte, then a clean write
    rd_data = 16'h0F0F;
    send_start();
    write_byte(8'h55, ack); check("rr_addr_ack", 16'(ack), 16'h0);
    for (int i = 0; i < 3; i++) clock_bit(1'b0, 1'b1, s);
    bus.sda_oe = 1'b0;
    wait_clk(2);
    bus.scl = 1'b1;
    wait_clk(1);
    check("rr_bit3_drive", 16'(bus.sda_in), 16'h0);
    reset = 1'b1;
    wait_clk(1);
    check("rr_sda_in", 16'(bus.sda_in), 16'h1);
    check("rr_busy", 16'(busy), 16'h0);
    check("rr_wr_data", wr_data, 16'h0000);
    reset = 1'b0;
    wait_clk(2);
    send_start();
    write_byte(8'h54, ack); check("rr_wr_addr_ack", 16'(ack), 16'h0);
    write_byte(8'h00, ack); check("rr_wr_b0_ack", 16'(ack), 16'h0);
    exp_q.push_back(16'h0001);
    write_byte(8'h01, ack); check("rr_wr_b1_ack", 16'(ack), 16'h0);
    send_stop();
    check("rr_final_wr_data", wr_data, 16'h0001);
    check("wr_pending", 16'(exp_q.size()), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
